// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read response sink.
package axi_rd_pkg;

    localparam int AXI_LEN_W  = 8;
    localparam int AXI_DW_DEF = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_sink_state_e;

    typedef struct packed {
        logic [AXI_DW_DEF-1:0] data;
        logic                  last;
    } rd_beat_t;

endpackage

// File: rtl/axi_rd_resp_sink_if.sv
// AR snoop and R channel bundle between the read bridge (master) and the response sink (slave).
interface axi_rd_resp_sink_if
    import axi_rd_pkg::*;
#(
    parameter int DW = AXI_DW_DEF
);
    logic                 arvalid;
    logic                 arready;
    logic [AXI_LEN_W-1:0] arlen;
    logic                 ar_hold;
    logic [DW-1:0]        rdata;
    logic                 rvalid;
    logic                 rlast;
    logic                 rready;

    modport master (
        output arvalid, arready, arlen, rdata, rvalid, rlast,
        input  ar_hold, rready
    );

    modport slave (
        input  arvalid, arready, arlen, rdata, rvalid, rlast,
        output ar_hold, rready
    );

endinterface

// File: rtl/axi_rd_resp_sink_fifo.sv
// Generic synchronous FIFO with registered storage; a pushed word is readable the cycle after.
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module rd_sink_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_rd_resp_sink.sv
// AXI read response sink: tracks burst lengths from AR, accepts R beats into a buffer, flags rlast errors.
// Optional RD_SINK_STATS_EN adds stat_beats/stat_bursts counters.
module axi_rd_resp_sink
    import axi_rd_pkg::*;
#(
    parameter int DW         = AXI_DW_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    axi_rd_resp_sink_if.slave rd,
    output logic [DW-1:0]     dout_data,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              err_rlast_early,
    output logic              err_rlast_miss,
    output logic              err_ar_ovf
`ifdef RD_SINK_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [15:0]       stat_bursts
`endif
);
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    rd_sink_state_e       state_q, state_d;
    logic [AXI_LEN_W-1:0] cur_len_q, cur_len_d;
    logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [AXI_LEN_W-1:0] len_head;
    logic                 len_full, len_empty, len_pop;
    logic                 buf_full, buf_empty;
    logic                 ar_fire, beat_acc, cnt_done, burst_end;
    logic                 early_q, early_d;
    logic                 miss_q, miss_d;
    logic                 ovf_q, ovf_d;
    beat_t                buf_in, buf_out;

    assign ar_fire    = rd.arvalid && rd.arready;
    assign rd.ar_hold = len_full;
    assign rd.rready  = (state_q == BURST) && !buf_full;
    assign beat_acc   = rd.rvalid && rd.rready;

    rd_sink_fifo #(.W(AXI_LEN_W), .DEPTH(MAX_OUTST)) u_len_q (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ar_fire),
        .push_data (rd.arlen),
        .pop       (len_pop),
        .pop_data  (len_head),
        .full      (len_full),
        .empty     (len_empty)
    );

    rd_sink_fifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (beat_acc),
        .push_data (buf_in),
        .pop       (dout_valid && dout_ready),
        .pop_data  (buf_out),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign dout_data  = buf_out.data;
    assign dout_last  = buf_out.last;
    assign dout_valid = !buf_empty;

    // A burst ends on the counted last beat or on an early rlast, whichever comes first.
    always_comb begin
        state_d    = state_q;
        cur_len_d  = cur_len_q;
        beat_cnt_d = beat_cnt_q;
        len_pop    = 1'b0;
        early_d    = 1'b0;
        miss_d     = 1'b0;
        cnt_done   = (beat_cnt_q == cur_len_q);
        burst_end  = beat_acc && (cnt_done || rd.rlast);
        buf_in     = '{data: rd.rdata, last: cnt_done || rd.rlast};
        case (state_q)
            IDLE: begin
                if (!len_empty) begin
                    len_pop    = 1'b1;
                    cur_len_d  = len_head;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
                    early_d    = !cnt_done && rd.rlast;
                    miss_d     = cnt_done && !rd.rlast;
                end
                if (burst_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q || (ar_fire && len_full && !len_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cur_len_q  <= '0;
            beat_cnt_q <= '0;
            early_q    <= 1'b0;
            miss_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_len_q  <= cur_len_d;
            beat_cnt_q <= beat_cnt_d;
            early_q    <= early_d;
            miss_q     <= miss_d;
            ovf_q      <= ovf_d;
        end
    end

    assign err_rlast_early = early_q;
    assign err_rlast_miss  = miss_q;
    assign err_ar_ovf      = ovf_q;

`ifdef RD_SINK_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [15:0] stat_bursts_q, stat_bursts_d;

    always_comb begin
        stat_beats_d  = stat_beats_q + {31'd0, beat_acc};
        stat_bursts_d = stat_bursts_q + {15'd0, burst_end};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_beats_q  <= '0;
            stat_bursts_q <= '0;
        end else begin
            stat_beats_q  <= stat_beats_d;
            stat_bursts_q <= stat_bursts_d;
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_bursts = stat_bursts_q;
`endif

endmodule

// File: tb/tb_axi_rd_resp_sink.sv
// Self-checking bench for axi_rd_resp_sink: table-driven single bursts, directed corner
// sequences and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_rd_resp_sink;
    import axi_rd_pkg::*;

    localparam int DW         = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUTST  = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_rd_resp_sink_if #(.DW(DW)) rd ();

    logic [DW-1:0] dout_data;
    logic          dout_last, dout_valid, dout_ready;
    logic          err_rlast_early, err_rlast_miss, err_ar_ovf;
`ifdef RD_SINK_STATS_EN
    logic [31:0]   stat_beats;
    logic [15:0]   stat_bursts;
`endif

    axi_rd_resp_sink #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .rd              (rd),
        .dout_data       (dout_data),
        .dout_last       (dout_last),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .err_rlast_early (err_rlast_early),
        .err_rlast_miss  (err_rlast_miss),
        .err_ar_ovf      (err_ar_ovf)
`ifdef RD_SINK_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_bursts     (stat_bursts)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Stimulus queues: lengths still to be issued on AR and beats still to be offered on R.
    int       ar_q[$];
    rd_beat_t r_q[$];
    bit       rand_mode = 0;
    bit       force_ar = 0;
    bit       dout_rdy_fix = 1;
    bit       r_took = 0;
    bit       ar_took = 0;

    // Reference model: lengths learned from AR, expected client beats, error/beat tallies.
    int       model_len_q[$];
    rd_beat_t exp_q[$];
    bit       m_active = 0;
    int       m_len = 0;
    int       m_k = 0;
    int       exp_early = 0, exp_miss = 0, exp_bursts = 0;
    int       obs_early = 0, obs_miss = 0, acc_beats = 0, popped = 0;
    rd_beat_t mb;
    bit       mlast;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Burst outcome follows the rules directly: last on the counted beat or on rlast, whichever is first.
    always @(negedge clk) begin
        if (resetn) begin
            r_took  = rd.rvalid && rd.rready;
            ar_took = rd.arvalid && rd.arready;
            if (ar_took && !rd.ar_hold) model_len_q.push_back(int'(rd.arlen));
            if (err_rlast_early) obs_early++;
            if (err_rlast_miss) obs_miss++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_dout", 64'd1, 64'd0);
                end else begin
                    mb = exp_q.pop_front();
                    checkOutput("dout_data", dout_data, mb.data);
                    checkOutput("dout_last", {63'd0, dout_last}, {63'd0, mb.last});
                    popped++;
                end
            end
            if (r_took) begin
                if (!m_active) begin
                    if (model_len_q.size() == 0) begin
                        checkOutput("beat_without_ar", 64'd1, 64'd0);
                        m_len = 0;
                    end else begin
                        m_len = model_len_q.pop_front();
                    end
                    m_k = 0;
                    m_active = 1;
                end
                mlast = (m_k == m_len) || rd.rlast;
                if (rd.rlast && m_k < m_len) exp_early++;
                if (m_k == m_len && !rd.rlast) exp_miss++;
                exp_q.push_back('{data: rd.rdata, last: mlast});
                acc_beats++;
                m_k++;
                if (mlast) begin
                    m_active = 0;
                    exp_bursts++;
                end
            end
        end
    end

    task automatic applyStimulus();
        if (r_took && r_q.size() > 0) void'(r_q.pop_front());
        if (ar_took && ar_q.size() > 0) void'(ar_q.pop_front());
        r_took  = 0;
        ar_took = 0;
        rd.rvalid  = (r_q.size() > 0) && (!rand_mode || $urandom_range(3) != 0);
        rd.rdata   = (r_q.size() > 0) ? r_q[0].data : '0;
        rd.rlast   = (r_q.size() > 0) ? r_q[0].last : 1'b0;
        rd.arvalid = (ar_q.size() > 0) && (force_ar || !rd.ar_hold) && (!rand_mode || $urandom_range(1) == 1);
        rd.arlen   = (ar_q.size() > 0) ? 8'(ar_q[0]) : 8'd0;
        rd.arready = !rand_mode || ($urandom_range(3) != 0);
        dout_ready = rand_mode ? ($urandom_range(3) != 0) : dout_rdy_fix;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    // mode 0: rlast on beat len; mode 1: early rlast on beat early_at; mode 2: rlast never set.
    task automatic queueBurst(input int len, input int mode, input int early_at);
        int n;
        rd_beat_t b;
        ar_q.push_back(len);
        n = (mode == 1) ? early_at + 1 : len + 1;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom(), $urandom()};
            b.last = (mode == 0 && i == len) || (mode == 1 && i == early_at);
            r_q.push_back(b);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((ar_q.size() != 0 || r_q.size() != 0 || exp_q.size() != 0 || dout_valid || m_active) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        repeat (3) step();
    endtask

    task automatic doReset();
        resetn = 1'b0;
        rd.arvalid = 0; rd.arready = 0; rd.arlen = 0;
        rd.rvalid = 0; rd.rdata = '0; rd.rlast = 0;
        dout_ready = 0;
        ar_q.delete(); r_q.delete(); model_len_q.delete(); exp_q.delete();
        r_took = 0; ar_took = 0; m_active = 0; m_k = 0; m_len = 0;
        exp_early = 0; exp_miss = 0; exp_bursts = 0;
        obs_early = 0; obs_miss = 0; acc_beats = 0; popped = 0;
        force_ar = 0; rand_mode = 0; dout_rdy_fix = 1;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rready"}, {63'd0, rd.rready}, 64'd0);
        checkOutput({tag, "_ar_hold"}, {63'd0, rd.ar_hold}, 64'd0);
        checkOutput({tag, "_dout_valid"}, {63'd0, dout_valid}, 64'd0);
        checkOutput({tag, "_dout_last"}, {63'd0, dout_last}, 64'd0);
        checkOutput({tag, "_dout_data"}, dout_data, 64'd0);
        checkOutput({tag, "_err_early"}, {63'd0, err_rlast_early}, 64'd0);
        checkOutput({tag, "_err_miss"}, {63'd0, err_rlast_miss}, 64'd0);
        checkOutput({tag, "_err_ovf"}, {63'd0, err_ar_ovf}, 64'd0);
    endtask

    typedef struct {
        int len;
        int mode;
        int early_at;
        int exp_beats;
        int exp_early;
        int exp_miss;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, e0, m0, a0, n;

        vecs[0] = '{len: 3,   mode: 0, early_at: 0, exp_beats: 4,   exp_early: 0, exp_miss: 0};
        vecs[1] = '{len: 3,   mode: 1, early_at: 1, exp_beats: 2,   exp_early: 1, exp_miss: 0};
        vecs[2] = '{len: 0,   mode: 2, early_at: 0, exp_beats: 1,   exp_early: 0, exp_miss: 1};
        vecs[3] = '{len: 255, mode: 0, early_at: 0, exp_beats: 256, exp_early: 0, exp_miss: 0};
        vecs[4] = '{len: 1,   mode: 1, early_at: 0, exp_beats: 1,   exp_early: 1, exp_miss: 0};
        vecs[5] = '{len: 6,   mode: 2, early_at: 0, exp_beats: 7,   exp_early: 0, exp_miss: 1};
        vecs[6] = '{len: 0,   mode: 0, early_at: 0, exp_beats: 1,   exp_early: 0, exp_miss: 0};

        doReset();
        resetn = 1'b0;
        #2;
        checkAllZero("reset");
        #1 resetn = 1'b1;

        for (int v = 0; v < 7; v++) begin
            p0 = popped; e0 = obs_early; m0 = obs_miss;
            queueBurst(vecs[v].len, vecs[v].mode, vecs[v].early_at);
            waitIdle(2000);
            checkOutput($sformatf("vec%0d_beats", v), 64'(popped - p0), 64'(vecs[v].exp_beats));
            checkOutput($sformatf("vec%0d_early", v), 64'(obs_early - e0), 64'(vecs[v].exp_early));
            checkOutput($sformatf("vec%0d_miss", v), 64'(obs_miss - m0), 64'(vecs[v].exp_miss));
        end

        // Client stalls: only FIFO_DEPTH beats fit, then rready must stay low until pops.
        p0 = popped; a0 = acc_beats;
        dout_rdy_fix = 0;
        queueBurst(5, 0, 0);
        repeat (20) step();
        checkOutput("bp_accepted", 64'(acc_beats - a0), 64'(FIFO_DEPTH));
        checkOutput("bp_rready_low", {63'd0, rd.rready}, 64'd0);
        checkOutput("bp_dout_valid", {63'd0, dout_valid}, 64'd1);
        dout_rdy_fix = 1;
        waitIdle(200);
        checkOutput("bp_total_out", 64'(popped - p0), 64'd6);

        // Length queue fill: the first length is taken straight into the active burst,
        // so the queue is full after the third fire and the fourth overflows.
        doReset();
        force_ar = 1;
        for (int i = 0; i < 4; i++) ar_q.push_back(3);
        repeat (4) step();
        checkOutput("ovf_hold_full", {63'd0, rd.ar_hold}, 64'd1);
        checkOutput("ovf_not_yet", {63'd0, err_ar_ovf}, 64'd0);
        step();
        checkOutput("ovf_set", {63'd0, err_ar_ovf}, 64'd1);
        checkOutput("ovf_queue_drained", 64'(ar_q.size()), 64'd0);
        repeat (5) step();
        checkOutput("ovf_sticky", {63'd0, err_ar_ovf}, 64'd1);

        // Reset in the middle of a burst, then a clean burst afterwards.
        doReset();
        queueBurst(3, 0, 0);
        n = 0;
        while (acc_beats < 2 && n < 50) begin
            step();
            n++;
        end
        checkOutput("midrst_two_beats", 64'(acc_beats), 64'd2);
        #2 resetn = 1'b0;
        #1;
        checkAllZero("midrst");
        doReset();
        queueBurst(2, 0, 0);
        waitIdle(200);
        checkOutput("midrst_clean_beats", 64'(popped), 64'd3);
        checkOutput("midrst_clean_errs", 64'(obs_early + obs_miss), 64'd0);

        // Randomized traffic with bubbles on every handshake.
        doReset();
        rand_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int len, r, mode, ea;
            len = ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(7));
            r = int'($urandom_range(9));
            mode = (r == 9) ? 2 : ((r >= 7 && len > 0) ? 1 : 0);
            ea = (mode == 1) ? int'($urandom_range(len - 1)) : 0;
            queueBurst(len, mode, ea);
        end
        waitIdle(20000);
        checkOutput("rand_early_count", 64'(obs_early), 64'(exp_early));
        checkOutput("rand_miss_count", 64'(obs_miss), 64'(exp_miss));
        checkOutput("rand_all_out", 64'(popped), 64'(acc_beats));
        checkOutput("rand_bursts", 64'(exp_bursts), 64'd40);
        checkOutput("rand_no_ovf", {63'd0, err_ar_ovf}, 64'd0);
`ifdef RD_SINK_STATS_EN
        checkOutput("stat_beats", 64'(stat_beats), 64'(acc_beats));
        checkOutput("stat_bursts", 64'(stat_bursts), 64'(exp_bursts));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
